// File: rtl/wdt_pkg.sv
// Shared types, defaults and sizing helper for the watchdog reset sequencer.
//   wdt_state_e : sequencer FSM states
//   WDT_*       : default clock rate, timeout and pulse/cooldown lengths
//   WDT_CNT_W   : bits needed to count 0..n-1 (at least 1)
package wdt_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MONITOR  = 2'd1,
    RESET    = 2'd2,
    COOLDOWN = 2'd3
  } wdt_state_e;

  localparam int unsigned WDT_CLOCK_FREQ   = 100_000_000;
  localparam int unsigned WDT_TIMEOUT_SEC  = 5;
  localparam int unsigned WDT_RESET_CYC    = 5;
  localparam int unsigned WDT_COOLDOWN_CYC = 16;

  function automatic int unsigned WDT_CNT_W(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/wdt_src_counter.sv
// Per-source heartbeat timeout counter.
//   clk, rst   : clock, synchronous active-high reset
//   hold       : 1 = not monitoring, counter forced to 0, no expiry
//   enable     : source enabled; a disabled source is held at 0
//   clear      : heartbeat kick, counter returns to 0
//   expire     : pulse, counter reaches TIMEOUT_CYC-1 with no kick this cycle
//   warn_hit   : enabled counter at or past the warning threshold
module wdt_src_counter
  import wdt_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 20,
  parameter int unsigned WARN_CYC    = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic hold,
  input  logic enable,
  input  logic clear,
  output logic expire,
  output logic warn_hit
);

  localparam int unsigned CW      = WDT_CNT_W(TIMEOUT_CYC);
  localparam logic [CW-1:0] LAST  = CW'(TIMEOUT_CYC - 1);
  localparam int unsigned WARN_AT = TIMEOUT_CYC - WARN_CYC;

  logic [CW-1:0] cnt_q;
  logic          at_last;

  assign at_last  = (cnt_q == LAST);
  assign expire   = !hold && enable && !clear && at_last;
  assign warn_hit = enable && (32'(cnt_q) >= WARN_AT);

  // Wrapping to 0 on expiry is harmless: the sequencer holds every counter
  // for the whole reset/cooldown window that follows.
  always_ff @(posedge clk) begin
    if (rst || hold || !enable || clear || at_last) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/watchdog_reset_sequencer.sv
// Multi-source watchdog: on any source timeout it drives a fixed reset pulse,
// then a cooldown window, and records which sources expired.
//   clk, rst      : clock, synchronous active-high reset
//   arm           : level, monitoring enabled
//   src_enable    : per-source enable
//   heartbeat     : per-source kick
//   clear_status  : pulse, clears timeout_src / timeout_count
//   reset_signal  : registered reset pulse (RESET_CYC cycles)
//   warn          : registered early warning, MONITOR only
//   busy          : high in RESET or COOLDOWN
//   timeout_src   : mask of sources behind the last expiry
//   timeout_count : saturating expiry count
module watchdog_reset_sequencer
  import wdt_pkg::*;
#(
  parameter int unsigned NUM_SRC      = 4,
  parameter int unsigned CLOCK_FREQ   = WDT_CLOCK_FREQ,
  parameter int unsigned TIMEOUT_CYC  = CLOCK_FREQ * WDT_TIMEOUT_SEC,
  parameter int unsigned WARN_CYC     = CLOCK_FREQ,
  parameter int unsigned RESET_CYC    = WDT_RESET_CYC,
  parameter int unsigned COOLDOWN_CYC = WDT_COOLDOWN_CYC
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               arm,
  input  logic [NUM_SRC-1:0] src_enable,
  input  logic [NUM_SRC-1:0] heartbeat,
  input  logic               clear_status,
  output logic               reset_signal,
  output logic               warn,
  output logic               busy,
  output logic [NUM_SRC-1:0] timeout_src,
  output logic [7:0]         timeout_count
);

  localparam int unsigned DUR_MAX = (RESET_CYC > COOLDOWN_CYC) ? RESET_CYC : COOLDOWN_CYC;
  localparam int unsigned DW      = WDT_CNT_W(DUR_MAX + 1);

  wdt_state_e        state_q, state_d;
  logic [DW-1:0]     dur_q, dur_d;
  logic              monitoring;
  logic              any_expire;
  logic [NUM_SRC-1:0] expire;
  logic [NUM_SRC-1:0] warn_hit;

  // Disarming in MONITOR discards same-cycle expiries, so arm gates the counters.
  assign monitoring = (state_q == MONITOR) && arm;
  assign any_expire = |expire;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    wdt_src_counter #(
      .TIMEOUT_CYC (TIMEOUT_CYC),
      .WARN_CYC    (WARN_CYC)
    ) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .hold     (!monitoring),
      .enable   (src_enable[i]),
      .clear    (heartbeat[i]),
      .expire   (expire[i]),
      .warn_hit (warn_hit[i])
    );
  end

  always_comb begin
    state_d = state_q;
    dur_d   = dur_q;
    unique case (state_q)
      IDLE: begin
        if (arm) state_d = MONITOR;
      end
      MONITOR: begin
        if (!arm) begin
          state_d = IDLE;
        end else if (any_expire) begin
          state_d = RESET;
          dur_d   = DW'(RESET_CYC);
        end
      end
      RESET: begin
        if (dur_q == DW'(1)) begin
          state_d = COOLDOWN;
          dur_d   = DW'(COOLDOWN_CYC);
        end else begin
          dur_d = dur_q - 1'b1;
        end
      end
      COOLDOWN: begin
        if (dur_q == DW'(1)) begin
          state_d = arm ? MONITOR : IDLE;
        end else begin
          dur_d = dur_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from next-state so they line up with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      dur_q         <= '0;
      reset_signal  <= 1'b0;
      warn          <= 1'b0;
      busy          <= 1'b0;
      timeout_src   <= '0;
      timeout_count <= '0;
    end else begin
      state_q      <= state_d;
      dur_q        <= dur_d;
      reset_signal <= (state_d == RESET);
      busy         <= (state_d == RESET) || (state_d == COOLDOWN);
      warn         <= monitoring && !any_expire && (|warn_hit);
      if (monitoring && any_expire) begin
        // A coincident clear restarts the count at this expiry.
        timeout_src <= expire;
        if (clear_status) begin
          timeout_count <= 8'd1;
        end else if (timeout_count != 8'hff) begin
          timeout_count <= timeout_count + 8'd1;
        end
      end else if (clear_status) begin
        timeout_src   <= '0;
        timeout_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_watchdog_reset_sequencer.sv
module tb_watchdog_reset_sequencer;

  localparam int T  = 20;
  localparam int W  = 5;
  localparam int R  = 5;
  localparam int C  = 4;

  logic       clk = 1'b0;
  logic       rst, arm, clear_status;
  logic [3:0] src_enable, heartbeat;
  logic       reset_signal, warn, busy;
  logic [3:0] timeout_src;
  logic [7:0] timeout_count;

  watchdog_reset_sequencer #(
    .NUM_SRC      (4),
    .CLOCK_FREQ   (100_000_000),
    .TIMEOUT_CYC  (T),
    .WARN_CYC     (W),
    .RESET_CYC    (R),
    .COOLDOWN_CYC (C)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .arm           (arm),
    .src_enable    (src_enable),
    .heartbeat     (heartbeat),
    .clear_status  (clear_status),
    .reset_signal  (reset_signal),
    .warn          (warn),
    .busy          (busy),
    .timeout_src   (timeout_src),
    .timeout_count (timeout_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: ages since last kick, and cycles left in the busy window
  // (pulse is the first R of those R+C cycles).
  int         age[4];
  bit         m_mon;
  int         m_busy_left;
  logic [3:0] m_src;
  int         m_cnt;
  bit         m_warn;
  int         m_total;
  bit         check_on = 1'b0;

  task automatic model_step();
    logic [3:0] mask;
    bit         w;
    if (rst) begin
      m_mon = 0; m_busy_left = 0; m_src = 0; m_cnt = 0; m_warn = 0;
      foreach (age[i]) age[i] = 0;
      return;
    end
    if (m_busy_left > 0) begin
      m_busy_left--;
      if (m_busy_left == 0) m_mon = arm;
      foreach (age[i]) age[i] = 0;
      m_warn = 0;
      if (clear_status) begin m_src = 0; m_cnt = 0; end
    end else if (!m_mon || !arm) begin
      m_mon = m_mon ? 1'b0 : arm;
      foreach (age[i]) age[i] = 0;
      m_warn = 0;
      if (clear_status) begin m_src = 0; m_cnt = 0; end
    end else begin
      mask = 0;
      w    = 0;
      for (int i = 0; i < 4; i++) begin
        if (src_enable[i] && age[i] >= T - W) w = 1;
        if (!src_enable[i] || heartbeat[i]) age[i] = 0;
        else if (age[i] == T - 1) mask[i] = 1'b1;
        else age[i]++;
      end
      if (mask != 0) begin
        m_src = mask;
        if (clear_status) m_cnt = 0;
        m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
        m_busy_left = R + C;
        m_warn = 0;
        m_total++;
        foreach (age[i]) age[i] = 0;
      end else begin
        m_warn = w;
        if (clear_status) begin m_src = 0; m_cnt = 0; end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (check_on) begin
      chk("reset_signal", 32'(reset_signal), 32'(m_busy_left > C));
      chk("busy", 32'(busy), 32'(m_busy_left > 0));
      chk("warn", 32'(warn), 32'(m_warn));
      chk("timeout_src", 32'(timeout_src), 32'(m_src));
      chk("timeout_count", 32'(timeout_count), 32'(m_cnt));
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  int seen;
  int guard;
  int target;
  bit hit;

  initial begin
    rst = 1; arm = 0; clear_status = 0; src_enable = 0; heartbeat = 0;
    wait_n(2);
    check_on = 1;
    chk("rst_reset_signal", 32'(reset_signal), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_count", 32'(timeout_count), 32'd0);
    rst = 0;
    wait_n(2);

    // Basic expiry on source 0
    src_enable = 4'b0001; arm = 1;
    wait_n(16); chk("basic_warn_e15", 32'(warn), 32'd0);
    wait_n(1);  chk("basic_warn_e16", 32'(warn), 32'd1);
    wait_n(3);  chk("basic_rs_e19", 32'(reset_signal), 32'd0);
    wait_n(1);
    chk("basic_rs_e20", 32'(reset_signal), 32'd1);
    chk("basic_busy_e20", 32'(busy), 32'd1);
    chk("basic_src", 32'(timeout_src), 32'h1);
    chk("basic_cnt", 32'(timeout_count), 32'd1);
    wait_n(4);  chk("basic_rs_e24", 32'(reset_signal), 32'd1);
    wait_n(1);  chk("basic_rs_e25", 32'(reset_signal), 32'd0);
    chk("basic_busy_e25", 32'(busy), 32'd1);
    wait_n(3);  chk("basic_busy_e28", 32'(busy), 32'd1);
    wait_n(1);  chk("basic_busy_e29", 32'(busy), 32'd0);
    arm = 0; wait_n(2);
    clear_status = 1; wait_n(1); clear_status = 0;
    chk("clear_cnt", 32'(timeout_count), 32'd0);
    chk("clear_src", 32'(timeout_src), 32'd0);

    // Steady heartbeats
    seen = 0; arm = 1;
    for (int i = 0; i < 300; i++) begin
      heartbeat = (i % 10 == 0) ? 4'b0001 : 4'b0000;
      wait_n(1);
      seen += int'(reset_signal) + int'(warn);
    end
    heartbeat = 0;
    chk("steady_quiet", 32'(seen), 32'd0);
    arm = 0; wait_n(2);

    // Heartbeat exactly at counter 19
    arm = 1;
    wait_n(20); heartbeat = 4'b0001;
    wait_n(1);  heartbeat = 0;
    chk("boundary_no_reset", 32'(reset_signal), 32'd0);
    chk("boundary_no_busy", 32'(busy), 32'd0);
    arm = 0; wait_n(2);

    // Simultaneous expiry of sources 1 and 2
    src_enable = 4'b0110; arm = 1;
    wait_n(21);
    chk("simul_src", 32'(timeout_src), 32'h6);
    chk("simul_cnt", 32'(timeout_count), 32'd1);
    wait_n(9); arm = 0; wait_n(2);

    // Disarm at counter 12, re-arm 3 cycles later
    src_enable = 4'b0001; arm = 1;
    wait_n(13); arm = 0;
    for (int k = 0; k < 3; k++) begin
      wait_n(1);
      chk("rearm_warn_off", 32'(warn), 32'd0);
    end
    arm = 1;
    wait_n(20); chk("rearm_rs_e19", 32'(reset_signal), 32'd0);
    wait_n(1);  chk("rearm_rs_e20", 32'(reset_signal), 32'd1);
    chk("rearm_cnt", 32'(timeout_count), 32'd2);

    // Reset on the 2nd pulse cycle
    wait_n(1); rst = 1;
    wait_n(1);
    chk("midrst_rs", 32'(reset_signal), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_src", 32'(timeout_src), 32'd0);
    chk("midrst_cnt", 32'(timeout_count), 32'd0);
    chk("midrst_state", 32'(dut.state_q), 32'(wdt_pkg::IDLE));
    rst = 0;

    // 256 expiries saturate the count
    target = m_total + 256;
    guard  = 0;
    while (m_total < target && guard < 20000) begin
      wait_n(1);
      guard++;
    end
    chk("sat_reached", 32'(m_total >= target), 32'd1);
    chk("sat_cnt", 32'(timeout_count), 32'd255);
    src_enable = 4'b0011;

    // clear_status on the same edge as the next expiry
    hit = 0; guard = 0;
    while (!hit && guard < 200) begin
      wait_n(1);
      guard++;
      if (m_mon && arm && m_busy_left == 0 && age[0] == T - 1 && age[1] == T - 1) begin
        clear_status = 1;
        wait_n(1);
        clear_status = 0;
        hit = 1;
        chk("clrexp_cnt", 32'(timeout_count), 32'd1);
        chk("clrexp_src", 32'(timeout_src), 32'h3);
      end
    end
    chk("clrexp_reached", 32'(hit), 32'd1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      arm          = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 49) == 0) src_enable = 4'($urandom_range(0, 15));
      for (int b = 0; b < 4; b++) heartbeat[b] = ($urandom_range(0, 19) == 0);
      clear_status = ($urandom_range(0, 63) == 0);
      rst          = ($urandom_range(0, 399) == 0);
      wait_n(1);
    end
    rst = 0; arm = 0; heartbeat = 0; clear_status = 0;
    wait_n(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/watchdog_reset_sequencer.md
# watchdog_reset_sequencer

Multi-source watchdog supervisor that schedules and sequences system resets. It monitors up to `NUM_SRC` heartbeat requesters (firmware cores, NVMe/FTL engines) with one timeout counter each. It raises an early warning, then drives a fixed-length `reset_signal` pulse followed by a cooldown window, and records which source(s) caused the reset. It sits between the heartbeat producers and the reset distribution logic, replacing single-source watchdog timers.

## Interface
Parameters:
- `NUM_SRC`, 4: number of heartbeat sources, 1..8.
- `CLOCK_FREQ`, 100_000_000: clock frequency in Hz (informational).
- `TIMEOUT_CYC`, 500_000_000 (5 s): cycles without a heartbeat before expiry.
- `WARN_CYC`, 100_000_000: warning lead time before expiry. Must be < `TIMEOUT_CYC`.
- `RESET_CYC`, 5: length of the `reset_signal` pulse in cycles. Must be ≥ 1.
- `COOLDOWN_CYC`, 16: dead cycles after the pulse. Must be ≥ 1.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  synchronous, active-high reset.
- `arm`  in  1  level; 1 = monitoring enabled.
- `src_enable`  in  NUM_SRC  per-source enable; a disabled source never expires.
- `heartbeat`  in  NUM_SRC  per-source kick; any 1-cycle-or-longer high clears that counter.
- `clear_status`  in  1  pulse; clears `timeout_src` and `timeout_count`.
- `reset_signal`  out  1  registered reset pulse to the system.
- `warn`  out  1  registered early-warning flag.
- `busy`  out  1  1 in RESET or COOLDOWN.
- `timeout_src`  out  NUM_SRC  sticky mask of the source(s) behind the last expiry.
- `timeout_count`  out  8  saturating count of expiries.

## Operation
- FSM states, in package enum `wdt_state_e`: IDLE, MONITOR, RESET, COOLDOWN.
- IDLE: all counters held at 0. If `arm`=1 at an edge, go to MONITOR; counters remain 0 after that edge.
- MONITOR, per source i, evaluated each edge in priority order:
  - `!src_enable[i]` or `heartbeat[i]`: counter i ← 0.
  - counter i == `TIMEOUT_CYC`−1: source i expires.
  - otherwise: counter i +1.
- MONITOR, `arm`=0: go to IDLE and clear all counters. Expiries that cycle are discarded.
- MONITOR, any expiry:
  - `timeout_src` ← mask of all sources expiring that cycle (replaces the old value).
  - `timeout_count` +1, saturating at 255.
  - Load the duration counter with `RESET_CYC` and go to RESET.
- RESET: `reset_signal`=1 for exactly `RESET_CYC` cycles. Heartbeats and `arm` are ignored and counters are held at 0. Then go to COOLDOWN.
- COOLDOWN: `COOLDOWN_CYC` cycles with `reset_signal`=0 and counters held at 0. Then go to MONITOR if `arm`=1, else IDLE.
- `warn` (registered): 1 in the cycle after any enabled counter holds a value ≥ `TIMEOUT_CYC`−`WARN_CYC` while in MONITOR. Forced 0 in all other states.
- `clear_status` coinciding with a new expiry: the expiry wins, so `timeout_src` = new mask and `timeout_count` = 1.
- Width rules:
  - Source counters are `$clog2(TIMEOUT_CYC)` bits, and the comparison against `TIMEOUT_CYC`−1 is done at that width.
  - The duration counter is sized for `max(RESET_CYC, COOLDOWN_CYC)`.

## Timing
- Reset values: `reset_signal`=0, `warn`=0, `busy`=0, `timeout_src`=0, `timeout_count`=0, state IDLE, all counters 0.
- Asserting `rst` mid-RESET: `reset_signal` drops after that edge, status is cleared, and the FSM returns to IDLE.
- Expiry latency: with `arm` sampled high at edge E0 and no heartbeat, expiry occurs at edge E(`TIMEOUT_CYC`). `reset_signal` is high from after that edge for `RESET_CYC` cycles. `busy` rises on the same edge.
- `busy` stays high for `RESET_CYC`+`COOLDOWN_CYC` cycles.
- A heartbeat in the same cycle a counter equals `TIMEOUT_CYC`−1 prevents expiry.
- Simultaneous expiries set every corresponding bit of `timeout_src` and increment `timeout_count` by 1, not by the number of sources.
- No combinational path from any input to any output.

## Structure
- Package `wdt_pkg` holds:
  - `wdt_state_e`;
  - default constants `WDT_CLOCK_FREQ`, `WDT_TIMEOUT_SEC`=5, `WDT_RESET_CYC`=5, `WDT_COOLDOWN_CYC`;
  - the `WDT_CNT_W` helper function.
- Sub-module `wdt_src_counter`: a per-source counter with clear, hold, enable, expire-pulse and warn-threshold outputs, instantiated `NUM_SRC` times with a generate block.
- The top level holds the FSM, the duration counter and the status registers.

## Test plan
All scenarios use `NUM_SRC`=4, `TIMEOUT_CYC`=20, `WARN_CYC`=5, `RESET_CYC`=5, `COOLDOWN_CYC`=4.

- Basic expiry:
  - Stimulus: arm, `src_enable`=0001, no heartbeats.
  - Response: `warn` rises 16 edges after arm. `reset_signal` is high exactly 5 cycles, starting after edge 20. `timeout_src`=0001, `timeout_count`=1. Monitoring resumes after 4 cooldown cycles.
- Steady heartbeats:
  - Stimulus: heartbeat on source 0 every 10 cycles for 300 cycles.
  - Response: `reset_signal` and `warn` stay 0.
- Heartbeat at the boundary and simultaneous expiry:
  - Stimulus: heartbeat exactly when counter 0 = 19.
  - Response: no reset.
  - Stimulus: sources 1 and 2 enabled together and left unkicked.
  - Response: `timeout_src`=0110, `timeout_count` +1.
- Re-arm:
  - Stimulus: drop `arm` at counter = 12, re-arm 3 cycles later.
  - Response: the next reset comes a full 20 edges after re-arm, and `warn` clears while disarmed.
- Reset mid-pulse:
  - Stimulus: `rst` on the 2nd cycle of `reset_signal`.
  - Response: `reset_signal`, `busy` and status are 0 after that edge, and the state is IDLE.
- Saturation and clear:
  - Stimulus: 256 consecutive expiries.
  - Response: `timeout_count`=255.
  - Stimulus: `clear_status` on the same edge as the next expiry.
  - Response: `timeout_count`=1 with the new mask.
